pixel_streamer: RTL and testbench
=================================

Name: pixel_streamer

Overview:
Front-end feeder for the digit-recognition network. It accepts 8-bit grayscale pixels over a valid/ready stream and converts each one to the network's signed fixed-point format. It drives the network's net_valid/net_data input one pixel per cycle. Only one image is in flight at a time: after a full frame is sent, the block holds off input until the network reports a result (net_out_valid).

Parameters:
dataWidth, 16, width of net_data (signed fixed-point, two's complement)
pixBits, 8, width of incoming pixel
fracBits, 12, fractional bits of network fixed-point format; constraint pixBits <= fracBits <= dataWidth-1
numPixels, 784, pixels per frame (28x28)
cntWidth, $clog2(numPixels), pixel index counter width

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
s_valid  input  1  upstream pixel valid
s_ready  output  1  block can accept a pixel this cycle
s_data  input  pixBits  unsigned pixel value
s_last  input  1  upstream marks final pixel of frame (checked only)
net_valid  output  1  to network: pixel valid
net_data  output  dataWidth  to network: fixed-point pixel
net_done  input  1  network result strobe (connect to net_out_valid)
busy  output  1  frame in progress or awaiting result
frame_err  output  1  one-cycle pulse on s_last/count mismatch
frames_done  output  16  count of completed frames (result received), wraps at 2^16

Behaviour:
- Reset (rst_n=0 at posedge clk): state IDLE, pixel counter 0, net_valid 0, net_data 0, frame_err 0, frames_done 0. s_ready=0 while rst_n=0.
- States: IDLE, STREAM, WAIT_RESULT.
- s_ready = rst_n && (state==IDLE || state==STREAM). It is combinational from state only and never depends on s_valid.
- Accept: a beat transfers on s_valid && s_ready at posedge.
- IDLE: on accept, go to STREAM, counter becomes 1. If numPixels==1, go to WAIT_RESULT instead.
- STREAM: on accept, counter increments. The accept at index numPixels-1 moves the block to WAIT_RESULT and clears the counter to 0.
- WAIT_RESULT: s_ready=0. On net_done=1, go to IDLE and increment frames_done.
- busy = (state != IDLE).
- Output path: registered, with latency 1. On accept, net_valid<=1 and net_data<=zero-extend(s_data) << (fracBits-pixBits), giving pixel/2^pixBits. The sign bit is always 0. In any cycle without an accept, net_valid<=0 and net_data holds its last value. No backpressure from the network; one pixel is presented per accepted beat.
- Gaps: s_valid may drop mid-frame. The counter and state hold, and net_valid is 0 during the gaps.
- s_last check: on an accept, frame_err<=1 for one cycle if (s_last==1 && index!=numPixels-1) or (s_last==0 && index==numPixels-1). Counting is unaffected; frames are delimited by count only.
- net_done outside WAIT_RESULT is ignored, with no state change and no counter change.
- net_done in the same cycle the last pixel is accepted is ignored; the block still enters WAIT_RESULT.
- Reset mid-frame or in WAIT_RESULT returns the block to IDLE with the counter at 0. The partial frame is discarded and net_valid is 0 on the following cycle.
- No timeout: WAIT_RESULT holds indefinitely until net_done.

Decomposition:
- Shared package nn_pkg:
  - constants DATA_WIDTH=16, FRAC_BITS=12, PIX_BITS=8, NUM_PIXELS=784
  - typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_WAIT} streamer_state_t
  - function pix_to_fixed (the conversion)
- No sub-module. The FSM, counter and output register live in one module.

Test Plan:
- Reset values: hold rst_n=0 for 3 cycles -> s_ready=0, net_valid=0, net_data=0, busy=0, frames_done=0. Release reset -> s_ready=1 next cycle.
- Full frame, continuous valid, pixels k%256, s_last on beat 783:
  - net_valid high for 784 consecutive cycles, starting 1 cycle after the first accept.
  - Pixel 255 yields net_data 0x0FF0; pixel 1 yields 0x0010.
  - After beat 783, s_ready=0 and busy=1; no frame_err.
- Result handshake:
  - While in WAIT_RESULT, drive s_valid=1 for 50 cycles -> no accepts, net_valid stays 0.
  - Pulse net_done -> IDLE next cycle, frames_done=1, s_ready=1.
- Random s_valid gaps (~50% duty) over one frame -> exactly 784 net_valid pulses and data order preserved; then net_done pulsed during the next frame's STREAM -> ignored, frames_done unchanged.
- s_last errors:
  - s_last asserted on beat 10 -> frame_err pulses once, 1 cycle after; streaming continues to 784.
  - s_last absent on beat 783 -> frame_err pulses once.
- Reset at beat 400:
  - State goes to IDLE, net_valid=0 next cycle.
  - A new 784-beat frame is then fully accepted and reaches WAIT_RESULT only after beat 783.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants, state encoding and pixel conversion for the
// digit-recognition network front end.
package nn_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned FRAC_BITS  = 12;
  localparam int unsigned PIX_BITS   = 8;
  localparam int unsigned NUM_PIXELS = 784;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WAIT
  } streamer_state_t;

  // Unsigned pixel p becomes p / 2^pixBits in a format with `shift` = fracBits - pixBits
  // extra fractional bits; callers truncate to their data width.
  function automatic logic [31:0] pix_to_fixed(input logic [31:0] pix,
                                               input int unsigned shift);
    return pix << shift;
  endfunction

endpackage

// File: rtl/pixel_streamer.sv
// Feeds one image at a time into the network: converts 8-bit pixels to signed fixed-point,
// streams them one per cycle, then holds off input until the network reports a result.
module pixel_streamer
  import nn_pkg::*;
#(
  parameter int unsigned dataWidth = DATA_WIDTH,
  parameter int unsigned pixBits   = PIX_BITS,
  parameter int unsigned fracBits  = FRAC_BITS,
  parameter int unsigned numPixels = NUM_PIXELS,
  parameter int unsigned cntWidth  = $clog2(numPixels)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [pixBits-1:0]   s_data,
  input  logic                 s_last,
  output logic                 net_valid,
  output logic [dataWidth-1:0] net_data,
  input  logic                 net_done,
  output logic                 busy,
  output logic                 frame_err,
  output logic [15:0]          frames_done
);

  // A single-pixel frame still needs a one-bit index register.
  localparam int unsigned    CntW    = (cntWidth < 1) ? 1 : cntWidth;
  localparam logic [CntW-1:0] LastIdx = CntW'(numPixels - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam int unsigned    Shift   = fracBits - pixBits;

  streamer_state_t      state_q, state_d;
  logic [CntW-1:0]      idx_q, idx_d;
  logic                 net_valid_q, net_valid_d;
  logic [dataWidth-1:0] net_data_q, net_data_d;
  logic                 frame_err_q, frame_err_d;
  logic [15:0]          frames_q, frames_d;

  logic accept;
  logic is_last;

  assign s_ready = rst_n && ((state_q == ST_IDLE) || (state_q == ST_STREAM));
  assign accept  = s_valid && s_ready;
  assign is_last = (idx_q == LastIdx);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frames_d = frames_q;
    case (state_q)
      ST_IDLE, ST_STREAM: begin
        if (accept) begin
          if (is_last) begin
            state_d = ST_WAIT;
            idx_d   = '0;
          end else begin
            state_d = ST_STREAM;
            idx_d   = idx_q + CntOne;
          end
        end
      end
      ST_WAIT: begin
        if (net_done) begin
          state_d  = ST_IDLE;
          frames_d = frames_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Frames are delimited by count alone; s_last only raises a diagnostic pulse.
  always_comb begin
    net_valid_d = accept;
    net_data_d  = net_data_q;
    frame_err_d = accept && (s_last != is_last);
    if (accept) begin
      net_data_d = dataWidth'(pix_to_fixed(32'(s_data), Shift));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      net_valid_q <= 1'b0;
      net_data_q  <= '0;
      frame_err_q <= 1'b0;
      frames_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      net_valid_q <= net_valid_d;
      net_data_q  <= net_data_d;
      frame_err_q <= frame_err_d;
      frames_q    <= frames_d;
    end
  end

  assign net_valid   = net_valid_q;
  assign net_data    = net_data_q;
  assign frame_err   = frame_err_q;
  assign frames_done = frames_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pixel_streamer.sv
// Directed bench for pixel_streamer: reset, full frames, result handshake, gaps,
// s_last diagnostics and mid-frame reset.
module tb_pixel_streamer;

  localparam int NP = 784;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        net_done = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_ready, net_valid, busy, frame_err;
  logic [15:0] net_data, frames_done;

  pixel_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .net_valid   (net_valid),
    .net_data    (net_data),
    .net_done    (net_done),
    .busy        (busy),
    .frame_err   (frame_err),
    .frames_done (frames_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [15:0] obs_q[$];
  int          nv_cyc[$];
  int          acc_cyc[$];
  int          err_cyc[$];
  bit          timed_out;

  task automatic sample();
    if (net_valid === 1'b1) begin
      obs_q.push_back(net_data);
      nv_cyc.push_back(cyc);
    end
    if (frame_err === 1'b1) err_cyc.push_back(cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic clear_obs();
    obs_q.delete();
    nv_cyc.delete();
    acc_cyc.delete();
    err_cyc.delete();
    timed_out = 1'b0;
  endtask

  // Pixel k is k%256, so its fixed-point image is {4'b0, k%256, 4'b0}.
  function automatic int data_mismatches(input int base);
    int n = 0;
    logic [7:0] p;
    for (int i = 0; i < obs_q.size(); i++) begin
      p = 8'((base + i) % 256);
      if (obs_q[i] !== {4'b0000, p, 4'b0000}) n++;
    end
    return n;
  endfunction

  task automatic pulse_done();
    net_done = 1'b1;
    step();
    net_done = 1'b0;
  endtask

  // Drives beats k_start..k_end-1; acc_cyc records the cycle each beat is presented and taken.
  task automatic run_frame(input bit gaps, input int err_beat, input bit drop_last,
                           input bit done_on_last, input int k_start, input int k_end,
                           input int tail);
    int k = k_start;
    int budget = 0;
    bit acc;
    while (k < k_end) begin
      if (budget >= 5000) begin
        timed_out = 1'b1;
        break;
      end
      s_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data   = 8'(k % 256);
      s_last   = ((k == NP - 1) && !drop_last) || (k == err_beat);
      acc      = s_valid && (s_ready === 1'b1);
      net_done = acc && done_on_last && (k == NP - 1);
      if (acc) begin
        acc_cyc.push_back(cyc);
        k++;
      end
      step();
      budget++;
    end
    s_valid  = 1'b0;
    s_last   = 1'b0;
    net_done = 1'b0;
    repeat (tail) step();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    repeat (3) step();
    checks++;
    if (s_ready !== 1'b0) begin
      failures++; $display("FAIL reset_s_ready: got %b want 0", s_ready);
    end
    checks++;
    if (net_valid !== 1'b0) begin
      failures++; $display("FAIL reset_net_valid: got %b want 0", net_valid);
    end
    checks++;
    if (net_data !== 16'h0000) begin
      failures++; $display("FAIL reset_net_data: got %h want 0000", net_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (frames_done !== 16'd0) begin
      failures++; $display("FAIL reset_frames_done: got %0d want 0", frames_done);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      failures++; $display("FAIL reset_frame_err: got %b want 0", frame_err);
    end
    rst_n   = 1'b1;
    s_valid = 1'b0;
    step();
    checks++;
    if (s_ready !== 1'b1) begin
      failures++; $display("FAIL release_s_ready: got %b want 1", s_ready);
    end
    checks++;
    if (net_valid !== 1'b0) begin
      failures++; $display("FAIL release_net_valid: got %b want 0", net_valid);
    end
  endtask

  task automatic test_full_frame();
    int first_nv, last_nv;
    clear_obs();
    run_frame(1'b0, -1, 1'b0, 1'b0, 0, NP, 3);
    first_nv = (nv_cyc.size() > 0) ? nv_cyc[0] : -1;
    last_nv  = (nv_cyc.size() > NP - 1) ? nv_cyc[NP-1] : -1;
    checks++;
    if (timed_out) begin
      failures++; $display("FAIL full_timeout: got timeout want %0d accepts", NP);
    end
    checks++;
    if (obs_q.size() != NP) begin
      failures++; $display("FAIL full_nv_count: got %0d want %0d", obs_q.size(), NP);
    end
    checks++;
    if (acc_cyc.size() == 0 || first_nv != acc_cyc[0] + 1) begin
      failures++; $display("FAIL full_latency: got first net_valid cycle %0d want accept+1", first_nv);
    end
    checks++;
    if (last_nv - first_nv != NP - 1) begin
      failures++; $display("FAIL full_consecutive: got span %0d want %0d", last_nv - first_nv, NP - 1);
    end
    checks++;
    if (obs_q.size() < 256 || obs_q[255] !== 16'h0FF0) begin
      failures++; $display("FAIL full_pix255: got %h want 0ff0", (obs_q.size() > 255) ? obs_q[255] : 16'hxxxx);
    end
    checks++;
    if (obs_q.size() < 2 || obs_q[1] !== 16'h0010) begin
      failures++; $display("FAIL full_pix1: got %h want 0010", (obs_q.size() > 1) ? obs_q[1] : 16'hxxxx);
    end
    checks++;
    if (data_mismatches(0) != 0) begin
      failures++; $display("FAIL full_data: got %0d bad words want 0", data_mismatches(0));
    end
    checks++;
    if (err_cyc.size() != 0) begin
      failures++; $display("FAIL full_frame_err: got %0d pulses want 0", err_cyc.size());
    end
    checks++;
    if (s_ready !== 1'b0) begin
      failures++; $display("FAIL full_s_ready: got %b want 0", s_ready);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL full_busy: got %b want 1", busy);
    end
  endtask

  task automatic test_result_handshake();
    clear_obs();
    s_valid = 1'b1;
    s_data  = 8'h55;
    repeat (50) step();
    s_valid = 1'b0;
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL wait_no_accept: got %0d net_valid pulses want 0", obs_q.size());
    end
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL wait_hold: got s_ready=%b busy=%b want 0/1", s_ready, busy);
    end
    checks++;
    if (frames_done !== 16'd0) begin
      failures++; $display("FAIL wait_frames: got %0d want 0", frames_done);
    end
    pulse_done();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL done_idle: got busy=%b want 0", busy);
    end
    checks++;
    if (frames_done !== 16'd1) begin
      failures++; $display("FAIL done_frames: got %0d want 1", frames_done);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      failures++; $display("FAIL done_s_ready: got %b want 1", s_ready);
    end
  endtask

  task automatic test_gaps();
    clear_obs();
    run_frame(1'b1, -1, 1'b0, 1'b0, 0, NP, 3);
    checks++;
    if (timed_out || obs_q.size() != NP) begin
      failures++; $display("FAIL gaps_count: got %0d pulses (timeout=%b) want %0d", obs_q.size(), timed_out, NP);
    end
    checks++;
    if (data_mismatches(0) != 0) begin
      failures++; $display("FAIL gaps_order: got %0d bad words want 0", data_mismatches(0));
    end
    checks++;
    if (err_cyc.size() != 0 || busy !== 1'b1) begin
      failures++; $display("FAIL gaps_end: got err=%0d busy=%b want 0/1", err_cyc.size(), busy);
    end
    pulse_done();
    checks++;
    if (frames_done !== 16'd2) begin
      failures++; $display("FAIL gaps_frames: got %0d want 2", frames_done);
    end
    // net_done during STREAM must be ignored
    clear_obs();
    run_frame(1'b0, -1, 1'b0, 1'b0, 0, 5, 0);
    pulse_done();
    checks++;
    if (frames_done !== 16'd2 || busy !== 1'b1 || s_ready !== 1'b1) begin
      failures++; $display("FAIL stream_done_ignored: got frames=%0d busy=%b ready=%b want 2/1/1", frames_done, busy, s_ready);
    end
    // net_done coincident with the final accept must also be ignored
    run_frame(1'b0, -1, 1'b0, 1'b1, 5, NP, 3);
    checks++;
    if (obs_q.size() != NP || data_mismatches(0) != 0) begin
      failures++; $display("FAIL resume_data: got %0d words %0d bad want %0d/0", obs_q.size(), data_mismatches(0), NP);
    end
    checks++;
    if (busy !== 1'b1 || frames_done !== 16'd2) begin
      failures++; $display("FAIL last_done_ignored: got busy=%b frames=%0d want 1/2", busy, frames_done);
    end
    pulse_done();
    checks++;
    if (frames_done !== 16'd3) begin
      failures++; $display("FAIL gaps_frames2: got %0d want 3", frames_done);
    end
  endtask

  task automatic test_s_last();
    int want;
    clear_obs();
    run_frame(1'b0, 10, 1'b0, 1'b0, 0, NP, 3);
    want = (acc_cyc.size() > 10) ? acc_cyc[10] + 1 : -1;
    checks++;
    if (err_cyc.size() != 1) begin
      failures++; $display("FAIL early_last_count: got %0d pulses want 1", err_cyc.size());
    end
    checks++;
    if (err_cyc.size() == 0 || err_cyc[0] != want) begin
      failures++; $display("FAIL early_last_time: got cycle %0d want %0d", (err_cyc.size() > 0) ? err_cyc[0] : -1, want);
    end
    checks++;
    if (obs_q.size() != NP || busy !== 1'b1) begin
      failures++; $display("FAIL early_last_stream: got %0d words busy=%b want %0d/1", obs_q.size(), busy, NP);
    end
    pulse_done();
    clear_obs();
    run_frame(1'b0, -1, 1'b1, 1'b0, 0, NP, 3);
    want = (acc_cyc.size() > NP - 1) ? acc_cyc[NP-1] + 1 : -1;
    checks++;
    if (err_cyc.size() != 1 || err_cyc[0] != want) begin
      failures++; $display("FAIL missing_last: got %0d pulses first at %0d want 1 at %0d", err_cyc.size(), (err_cyc.size() > 0) ? err_cyc[0] : -1, want);
    end
    pulse_done();
    checks++;
    if (frames_done !== 16'd5) begin
      failures++; $display("FAIL s_last_frames: got %0d want 5", frames_done);
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    run_frame(1'b0, -1, 1'b0, 1'b0, 0, 400, 0);
    checks++;
    if (net_valid !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL mid_streaming: got net_valid=%b busy=%b want 1/1", net_valid, busy);
    end
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'd144;
    step();
    checks++;
    if (net_valid !== 1'b0 || net_data !== 16'h0000) begin
      failures++; $display("FAIL mid_reset_out: got net_valid=%b net_data=%h want 0/0000", net_valid, net_data);
    end
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || frames_done !== 16'd0) begin
      failures++; $display("FAIL mid_reset_state: got busy=%b ready=%b frames=%0d want 0/0/0", busy, s_ready, frames_done);
    end
    rst_n   = 1'b1;
    s_valid = 1'b0;
    step();
    clear_obs();
    run_frame(1'b0, -1, 1'b0, 1'b0, 0, NP - 1, 0);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL after_reset_782: got ready=%b busy=%b want 1/1", s_ready, busy);
    end
    run_frame(1'b0, -1, 1'b0, 1'b0, NP - 1, NP, 3);
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL after_reset_783: got ready=%b busy=%b want 0/1", s_ready, busy);
    end
    checks++;
    if (obs_q.size() != NP || data_mismatches(0) != 0 || err_cyc.size() != 0) begin
      failures++; $display("FAIL after_reset_frame: got %0d words %0d bad %0d errs want %0d/0/0", obs_q.size(), data_mismatches(0), err_cyc.size(), NP);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_result_handshake();
    test_gaps();
    test_s_last();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
